// File: rtl/fir_sample_scheduler_if.sv
// Handshake and data bundle between the stimulus/config side, the FIR datapath
// and fir_sample_scheduler. The master side drives config and filter output.
interface fir_sample_scheduler_if #(
  parameter int N  = 16,
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          start;
  logic          stop;
  logic [7:0]    rate_div;
  logic [AW-1:0] loop_len;
  logic [15:0]   out_count;
  logic [N-1:0]  fir_data_in;
  logic          fir_en;
  logic [N-1:0]  fir_data_out;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, rate_div, loop_len, out_count,
    output fir_data_out,
    input  fir_data_in, fir_en, out_data, out_valid, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, rate_div, loop_len, out_count,
    input  fir_data_out,
    output fir_data_in, fir_en, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/fir_sample_scheduler.sv
// Plays a 32-entry waveform memory into the FIR datapath at a programmable rate
// and qualifies its output. Define FIR_SCHED_FLUSH_EN to add the zero-flush phase.
//
// state | meaning
// IDLE  | waiting for start, memory writable
// RUN   | issuing memory samples every rate_div+1 cycles
// FLUSH | issuing TAPS zero samples (FIR_SCHED_FLUSH_EN only)
// DRAIN | no issue, waiting for flagged samples to leave the pipe
// DONE  | run complete, done high, memory writable
module fir_sample_scheduler #(
  parameter int N       = 16,
  parameter int AW      = 5,
  parameter int LATENCY = 1,
  parameter int TAPS    = 8
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  fir_sample_scheduler_if.slave   bus
);

  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef FIR_SCHED_FLUSH_EN
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam int         FW      = $clog2(TAPS + 1);
`endif

  if (LATENCY < 1 || TAPS < 1) begin : g_bad_params
    $error("fir_sample_scheduler: LATENCY and TAPS must be >= 1");
  end

  logic [N-1:0]         mem_q [DEPTH];
  logic [2:0]           state_q, state_d;
  logic [7:0]           rate_q, rate_d;
  logic [AW-1:0]        loop_q, loop_d;
  logic [15:0]          count_q, count_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [7:0]           div_q, div_d;
  logic [15:0]          issued_q, issued_d;
  logic [LATENCY-1:0]   pipe_q, pipe_d;
  logic [N-1:0]         out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
`ifdef FIR_SCHED_FLUSH_EN
  logic [FW-1:0]        flush_q, flush_d;
`endif

  logic idle_like;
  logic run_issue;
  logic flush_issue;
  logic last_issue;
  logic [7:0] div_next;

  assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign run_issue  = (state_q == S_RUN) && (div_q == 8'd0) && !bus.stop;
`ifdef FIR_SCHED_FLUSH_EN
  assign flush_issue = (state_q == S_FLUSH) && (div_q == 8'd0) && !bus.stop;
`else
  assign flush_issue = 1'b0;
`endif
  assign last_issue = run_issue && (count_q != 16'd0) && (issued_q + 16'd1 == count_q);
  assign div_next   = (div_q == rate_q) ? 8'd0 : div_q + 8'd1;

  // Only real samples carry a flag; flush zeros travel through unflagged.
  if (LATENCY == 1) begin : g_pipe1
    assign pipe_d = run_issue;
  end else begin : g_pipen
    assign pipe_d = {pipe_q[LATENCY-2:0], run_issue};
  end

  assign out_valid_d = pipe_q[LATENCY-1];
  assign out_data_d  = pipe_q[LATENCY-1] ? bus.fir_data_out : out_data_q;

  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    loop_d   = loop_q;
    count_d  = count_q;
    addr_d   = addr_q;
    div_d    = div_q;
    issued_d = issued_q;
`ifdef FIR_SCHED_FLUSH_EN
    flush_d  = flush_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          rate_d   = bus.rate_div;
          loop_d   = bus.loop_len;
          count_d  = bus.out_count;
          addr_d   = '0;
          div_d    = 8'd0;
          issued_d = 16'd0;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_DRAIN;
        end else begin
          div_d = div_next;
          if (run_issue) begin
            addr_d   = (addr_q == loop_q) ? '0 : addr_q + 1'b1;
            issued_d = issued_q + 16'd1;
          end
          if (last_issue) begin
`ifdef FIR_SCHED_FLUSH_EN
            state_d = S_FLUSH;
            flush_d = '0;
`else
            state_d = S_DRAIN;
`endif
          end
        end
      end
`ifdef FIR_SCHED_FLUSH_EN
      S_FLUSH: begin
        if (bus.stop) begin
          state_d = S_DRAIN;
        end else begin
          div_d = div_next;
          if (flush_issue) begin
            flush_d = flush_q + FW'(1);
            if (flush_q == FW'(TAPS - 1)) state_d = S_DRAIN;
          end
        end
      end
`endif
      S_DRAIN: begin
        if (pipe_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rate_q      <= 8'd0;
      loop_q      <= '0;
      count_q     <= 16'd0;
      addr_q      <= '0;
      div_q       <= 8'd0;
      issued_q    <= 16'd0;
      pipe_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef FIR_SCHED_FLUSH_EN
      flush_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      loop_q      <= loop_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      div_q       <= div_d;
      issued_q    <= issued_d;
      pipe_q      <= pipe_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef FIR_SCHED_FLUSH_EN
      flush_q     <= flush_d;
`endif
    end
  end

  // Waveform memory is deliberately unreset so a reload is not needed after reset.
  always_ff @(posedge clk_i) begin
    if (bus.wr_en && idle_like) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.fir_en      = run_issue | flush_issue;
  assign bus.fir_data_in = run_issue ? mem_q[addr_q] : '0;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_fir_sample_scheduler.sv
// Directed bench for fir_sample_scheduler: per-run expected schedule computed from
// the issue/latency rules, checked every cycle, plus hand-computed pins.
module tb_fir_sample_scheduler;
  localparam int L    = 1;
  localparam int TAPS = 8;
  localparam int MAXT = 160;

  logic clk;
  logic rst_n;
  int   t;
  int   mode;
  int   checks;
  int   failures;
  int   done_t;
  bit   last_done;
  int   en_cnt;
  int   val_cnt;
  logic [15:0] issue_d [64];
  int          issue_t [64];
  logic [15:0] mem_m [32];

  bit          e_en   [MAXT];
  logic [15:0] e_din  [MAXT];
  bit          e_val  [MAXT];
  logic [15:0] e_dout [MAXT];
  bit          e_busy [MAXT];
  bit          e_done [MAXT];

  fir_sample_scheduler_if #(.N(16), .AW(5)) bus ();

  fir_sample_scheduler #(.N(16), .AW(5), .LATENCY(L), .TAPS(TAPS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] filt(input logic [15:0] x);
    return x * 16'd3 + 16'h0101;
  endfunction

  // Stand-in filter with one cycle of latency.
  always @(posedge clk) begin
    if (bus.fir_en) bus.fir_data_out <= filt(bus.fir_data_in);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic build_model(input int rate, input int loop_l, input int cnt, input int stop_t);
    int n, ti, tl, tv;
    bit stopped;
    for (int i = 0; i < MAXT; i++) begin
      e_en[i] = 0; e_din[i] = '0; e_val[i] = 0; e_dout[i] = '0;
    end
    n = 0; tl = 0; tv = 0; stopped = 0;
    forever begin
      ti = 1 + n * (rate + 1);
      if (cnt != 0 && n >= cnt) break;
      if (stop_t != 0 && ti >= stop_t) begin stopped = 1; break; end
      if (ti >= MAXT - 8) break;
      e_en[ti]  = 1;
      e_din[ti] = mem_m[n % (loop_l + 1)];
      tv = ti + L + 1;
      e_val[tv]  = 1;
      e_dout[tv] = filt(e_din[ti]);
      tl = ti;
      n++;
    end
    done_t = (n > 0) ? tv + 1 : 2;
    if (stopped && stop_t + 2 > done_t) done_t = stop_t + 2;
`ifdef FIR_SCHED_FLUSH_EN
    if (!stopped && cnt != 0) begin
      for (int f = 0; f < TAPS; f++) begin
        ti = tl + (f + 1) * (rate + 1);
        e_en[ti]  = 1;
        e_din[ti] = '0;
        if (ti + 2 > done_t) done_t = ti + 2;
      end
    end
`endif
    for (int i = 0; i < MAXT; i++) begin
      e_busy[i] = (i >= 1) && (i < done_t);
      e_done[i] = (i == 0) ? last_done : (i >= done_t);
    end
  endtask

  always @(negedge clk) begin
    bit xe, xv, xb, xd;
    logic [15:0] xdin, xdout;
    if (rst_n) begin
      if (mode == 0) begin
        xe = 0; xv = 0; xb = 0; xd = 0; xdin = '0; xdout = '0;
      end else if (t < MAXT) begin
        xe = e_en[t]; xv = e_val[t]; xb = e_busy[t]; xd = e_done[t];
        xdin = e_din[t]; xdout = e_dout[t];
      end else begin
        xe = 0; xv = 0; xb = 0; xd = 1; xdin = '0; xdout = '0;
      end
      chk("fir_en", bus.fir_en, xe);
      chk("out_valid", bus.out_valid, xv);
      chk("busy", bus.busy, xb);
      chk("done", bus.done, xd);
      if (xe) chk("fir_data_in", bus.fir_data_in, xdin);
      if (xv) chk("out_data", bus.out_data, xdout);
      if (mode == 1 && bus.fir_en === 1'b1 && en_cnt < 64) begin
        issue_d[en_cnt] = bus.fir_data_in;
        issue_t[en_cnt] = t;
        en_cnt++;
      end
      if (mode == 1 && bus.out_valid === 1'b1) val_cnt++;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_fir_en"}, bus.fir_en, 0);
    chk({tag, "_fir_data_in"}, bus.fir_data_in, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  task automatic load_mem(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < 32; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(i);
      bus.wr_data = base + step * 16'(i);
      mem_m[i]    = base + step * 16'(i);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic run_case(input int rate, input int loop_l, input int cnt, input int stop_t,
                          input int busy_start_t, input int wr_t, input int abort_t,
                          input bit stop_with_start);
    build_model(rate, loop_l, cnt, stop_t);
    en_cnt = 0; val_cnt = 0;
    bus.rate_div  = 8'(rate);
    bus.loop_len  = 5'(loop_l);
    bus.out_count = 16'(cnt);
    bus.start     = 1'b1;
    bus.stop      = stop_with_start;
    mode = 1;
    t = 0;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    // Scramble config so anything not latched at start shows up as a schedule error.
    bus.rate_div  = 8'hFF;
    bus.loop_len  = 5'd0;
    bus.out_count = 16'd1;
    while (t < done_t + 3 && t < MAXT) begin
      bus.stop    = (t == stop_t);
      bus.start   = (t == busy_start_t);
      bus.wr_en   = (t == wr_t);
      bus.wr_addr = 5'd0;
      bus.wr_data = 16'hBEEF;
      if (abort_t != 0 && t == abort_t) begin
        mode = 0;
        bus.stop = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        last_done = 0;
        return;
      end
      tick();
    end
    bus.stop = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
    last_done = 1;
  endtask

  logic [15:0] exp_c [10];

  initial begin
    checks = 0; failures = 0; mode = 0; t = 0; last_done = 0;
    en_cnt = 0; val_cnt = 0; done_t = 0;
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0; bus.stop = 0;
    bus.rate_div = '0; bus.loop_len = '0; bus.out_count = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all_zero("reset");

    load_mem(16'h0000, 16'h0001);

    // Back-to-back: 4 issues of 0..3.
    run_case(0, 31, 4, 0, 0, 0, 0, 0);
    chk("A_en_cnt", en_cnt, 4);
    chk("A_val_cnt", val_cnt, 4);
    for (int i = 0; i < 4; i++) chk("A_issue_data", issue_d[i], 16'(i));

    // Divided rate, start and stop together from DONE.
    run_case(2, 31, 3, 0, 0, 0, 0, 1);
    chk("B_val_cnt", val_cnt, 3);
    chk("B_spacing", issue_t[1] - issue_t[0], 3);
    chk("B_first_t", issue_t[0], 1);

    // Short loop with a start attempt while busy.
    exp_c = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    run_case(0, 3, 10, 0, 3, 0, 0, 0);
    chk("C_en_cnt", en_cnt, 10);
    for (int i = 0; i < 10; i++) chk("C_wrap_addr", issue_d[i], exp_c[i]);

    // Free-run stopped after 5 issues.
    run_case(0, 31, 0, 6, 0, 0, 0, 0);
    chk("D_en_cnt", en_cnt, 5);
    chk("D_val_cnt", val_cnt, 5);

    // New waveform, write attempt while running, reset mid-run, then replay.
    load_mem(16'h1000, 16'h0007);
    run_case(1, 31, 6, 0, 0, 2, 5, 0);
    run_case(1, 31, 6, 0, 0, 2, 0, 0);
    chk("E_replay_first", issue_d[0], 16'h1000);
    chk("E_replay_second", issue_d[1], 16'h1007);
    chk("E_en_cnt", en_cnt, 6);

    // Two counted outputs, with or without flush.
    run_case(0, 31, 2, 0, 0, 0, 0, 0);
    chk("F_val_cnt", val_cnt, 2);
`ifdef FIR_SCHED_FLUSH_EN
    chk("F_en_cnt", en_cnt, 10);
    chk("F_flush_zero", issue_d[2], 16'h0000);
`else
    chk("F_en_cnt", en_cnt, 2);
    chk("F_done_t", done_t, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
